// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: serialized load/store requests, fixed latency,
// byte-masked word array, registered response held under backpressure.
module dmem_responder #(
  parameter int                DATA_W     = 64,
  parameter int                ADDR_W     = 32,
  parameter int                DEPTH_LOG2 = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h8000_0000,
  parameter int                LATENCY    = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_wen_i,
  input  logic [ADDR_W-1:0]   req_addr_i,
  input  logic [DATA_W-1:0]   req_wdata_i,
  input  logic [DATA_W/8-1:0] req_wmask_i,
  output logic                resp_valid_o,
  input  logic                resp_ready_i,
  output logic [DATA_W-1:0]   resp_rdata_o,
  output logic                resp_err_o,
  output logic                busy_o
);

  localparam int LANES    = DATA_W / 8;
  localparam int OFF_BITS = $clog2(LANES);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                state;
  logic [3:0]            cnt;
  logic                  lat_wen;
  logic [ADDR_W-1:0]     lat_addr;
  logic [DATA_W-1:0]     lat_wdata;
  logic [LANES-1:0]      lat_wmask;

  logic [DATA_W-1:0]     mem [2**DEPTH_LOG2];

  logic                  c_wen;
  logic [ADDR_W-1:0]     c_addr;
  logic [DATA_W-1:0]     c_wdata;
  logic [LANES-1:0]      c_wmask;
  logic [ADDR_W-1:0]     offset;
  logic [ADDR_W-1:0]     idx_full;
  logic [DEPTH_LOG2-1:0] idx;
  logic                  range_err;
  logic                  commit;

  assign req_ready_o = (state == IDLE) && !rst;
  assign busy_o      = (state != IDLE);

  // With LATENCY = 1 the commit happens on the accept edge, so it must use the live request.
  always_comb begin
    c_wen   = lat_wen;
    c_addr  = lat_addr;
    c_wdata = lat_wdata;
    c_wmask = lat_wmask;
    if (state == IDLE) begin
      c_wen   = req_wen_i;
      c_addr  = req_addr_i;
      c_wdata = req_wdata_i;
      c_wmask = req_wmask_i;
    end
  end

  always_comb begin
    offset    = c_addr - BASE_ADDR;
    idx_full  = offset >> OFF_BITS;
    idx       = idx_full[DEPTH_LOG2-1:0];
    range_err = (c_addr < BASE_ADDR) || ((idx_full >> DEPTH_LOG2) != '0);
    commit    = !rst && (((state == IDLE) && req_valid_i && (LATENCY == 1)) ||
                         ((state == WAIT) && (cnt == 4'd0)));
  end

  always_ff @(posedge clk) begin
    if (commit && c_wen && !range_err) begin
      for (int b = 0; b < LANES; b++) begin
        if (c_wmask[b]) mem[idx][b*8 +: 8] <= c_wdata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      resp_valid_o <= 1'b0;
      resp_rdata_o <= '0;
      resp_err_o   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid_i) begin
            lat_wen   <= req_wen_i;
            lat_addr  <= req_addr_i;
            lat_wdata <= req_wdata_i;
            lat_wmask <= req_wmask_i;
            cnt       <= 4'(LATENCY - 1);
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
        end
        RESP: begin
          if (resp_ready_i) begin
            state        <= IDLE;
            resp_valid_o <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
      // Requests are serialized, so the read never races a write to the same word.
      if (commit) begin
        state        <= RESP;
        resp_valid_o <= 1'b1;
        resp_err_o   <= range_err;
        resp_rdata_o <= (c_wen || range_err) ? '0 : mem[idx];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance at LATENCY 2, one at LATENCY 4
// sharing the request/response bus but with separate valid and reset.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        a_rst, b_rst;
  logic        a_req_valid, b_req_valid;
  logic        a_req_ready, b_req_ready;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_wmask;
  logic        resp_ready;
  logic        a_resp_valid, b_resp_valid;
  logic [63:0] a_resp_rdata, b_resp_rdata;
  logic        a_resp_err, b_resp_err;
  logic        a_busy, b_busy;

  int num_checks   = 0;
  int num_failures = 0;
  bit cur          = 1'b0;

  logic        cur_ready, cur_valid, cur_err;
  logic [63:0] cur_rdata;
  assign cur_ready = cur ? b_req_ready  : a_req_ready;
  assign cur_valid = cur ? b_resp_valid : a_resp_valid;
  assign cur_rdata = cur ? b_resp_rdata : a_resp_rdata;
  assign cur_err   = cur ? b_resp_err   : a_resp_err;

  always #5 clk = ~clk;

  dmem_responder #(.LATENCY(2)) dut_a (
    .clk(clk), .rst(a_rst), .req_valid_i(a_req_valid), .req_ready_o(a_req_ready),
    .req_wen_i(req_wen), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .req_wmask_i(req_wmask), .resp_valid_o(a_resp_valid), .resp_ready_i(resp_ready),
    .resp_rdata_o(a_resp_rdata), .resp_err_o(a_resp_err), .busy_o(a_busy)
  );

  dmem_responder #(.LATENCY(4)) dut_b (
    .clk(clk), .rst(b_rst), .req_valid_i(b_req_valid), .req_ready_o(b_req_ready),
    .req_wen_i(req_wen), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .req_wmask_i(req_wmask), .resp_valid_o(b_resp_valid), .resp_ready_i(resp_ready),
    .resp_rdata_o(b_resp_rdata), .resp_err_o(b_resp_err), .busy_o(b_busy)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    num_checks++;
    if (observed !== expected) begin
      num_failures++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  // One full transaction on the selected instance; lat = 0 means no response arrived.
  task automatic applyStimulus(input bit sel, input logic wen, input logic [31:0] addr,
                               input logic [63:0] wdata, input logic [7:0] wmask,
                               output int lat, output logic [63:0] rdata, output logic err);
    cur        = sel;
    resp_ready = 1'b1;
    req_wen    = wen;
    req_addr   = addr;
    req_wdata  = wdata;
    req_wmask  = wmask;
    for (int i = 0; i < 20 && !cur_ready; i++) @(negedge clk);
    if (sel) b_req_valid = 1'b1; else a_req_valid = 1'b1;
    @(posedge clk);
    #1;
    a_req_valid = 1'b0;
    b_req_valid = 1'b0;
    lat   = 0;
    rdata = '1;
    err   = 1'bx;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk);
      #1;
      if (cur_valid) begin
        lat   = i;
        rdata = cur_rdata;
        err   = cur_err;
        break;
      end
    end
    @(posedge clk);
    #1;
    @(negedge clk);
  endtask

  int          lat;
  logic [63:0] rdata;
  logic        err;
  int          seen;

  initial begin
    a_rst = 1'b1; b_rst = 1'b1;
    a_req_valid = 1'b0; b_req_valid = 1'b0;
    req_wen = 1'b0; req_addr = '0; req_wdata = '0; req_wmask = '0;
    resp_ready = 1'b1;

    $display("[TB] reset");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("rst_ready", 64'(a_req_ready), 64'd0);
    end
    checkOutput("rst_valid", 64'(a_resp_valid), 64'd0);
    checkOutput("rst_busy", 64'(a_busy), 64'd0);
    checkOutput("rst_rdata", a_resp_rdata, 64'd0);
    a_rst = 1'b0; b_rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_ready", 64'(a_req_ready), 64'd1);
    checkOutput("post_rst_valid", 64'(a_resp_valid), 64'd0);

    $display("[TB] store then load");
    applyStimulus(0, 1'b1, 32'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF, lat, rdata, err);
    checkOutput("st_latency", 64'(lat), 64'd2);
    checkOutput("st_rdata", rdata, 64'd0);
    checkOutput("st_err", 64'(err), 64'd0);
    applyStimulus(0, 1'b0, 32'h8000_0010, 64'h0, 8'h00, lat, rdata, err);
    checkOutput("ld_latency", 64'(lat), 64'd2);
    checkOutput("ld_rdata", rdata, 64'h1122_3344_5566_7788);
    checkOutput("ld_err", 64'(err), 64'd0);

    $display("[TB] partial mask");
    applyStimulus(0, 1'b1, 32'h8000_0020, 64'hAAAA_AAAA_AAAA_AAAA, 8'hFF, lat, rdata, err);
    applyStimulus(0, 1'b1, 32'h8000_0020, 64'h0000_0000_0000_BB00, 8'h02, lat, rdata, err);
    applyStimulus(0, 1'b0, 32'h8000_0020, 64'h0, 8'h00, lat, rdata, err);
    checkOutput("mask_rdata", rdata, 64'hAAAA_AAAA_AAAA_BBAA);

    $display("[TB] out of range");
    applyStimulus(0, 1'b1, 32'h8000_0000, 64'hDEAD_BEEF_0BAD_F00D, 8'hFF, lat, rdata, err);
    checkOutput("w0_err", 64'(err), 64'd0);
    applyStimulus(0, 1'b0, 32'h7FFF_FFF8, 64'h0, 8'h00, lat, rdata, err);
    checkOutput("low_err", 64'(err), 64'd1);
    checkOutput("low_rdata", rdata, 64'd0);
    applyStimulus(0, 1'b1, 32'h8000_2000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, lat, rdata, err);
    checkOutput("high_err", 64'(err), 64'd1);
    checkOutput("high_rdata", rdata, 64'd0);
    applyStimulus(0, 1'b0, 32'h8000_0000, 64'h0, 8'h00, lat, rdata, err);
    checkOutput("w0_rdata", rdata, 64'hDEAD_BEEF_0BAD_F00D);
    checkOutput("w0_ld_err", 64'(err), 64'd0);

    $display("[TB] backpressure");
    cur = 1'b0;
    resp_ready = 1'b0;
    req_wen = 1'b0; req_addr = 32'h8000_0010; req_wmask = 8'h00;
    a_req_valid = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("bp_busy", 64'(a_busy), 64'd1);
    req_addr = 32'h8000_0020;
    seen = 0;
    for (int i = 0; i < 20 && !a_resp_valid; i++) begin
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 5; i++) begin
      if (a_resp_valid && a_resp_rdata == 64'h1122_3344_5566_7788 && !a_req_ready) seen++;
      @(posedge clk);
      #1;
    end
    checkOutput("bp_stable_cycles", 64'(seen), 64'd5);
    checkOutput("bp_rdata", a_resp_rdata, 64'h1122_3344_5566_7788);
    checkOutput("bp_ready_held", 64'(a_req_ready), 64'd0);
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("bp_idle_ready", 64'(a_req_ready), 64'd1);
    checkOutput("bp_idle_valid", 64'(a_resp_valid), 64'd0);
    @(posedge clk);
    #1;
    checkOutput("bp_queued_busy", 64'(a_busy), 64'd1);
    a_req_valid = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (a_resp_valid) begin
        lat = i;
        break;
      end
    end
    checkOutput("bp_queued_latency", 64'(lat), 64'd2);
    checkOutput("bp_queued_rdata", a_resp_rdata, 64'hAAAA_AAAA_AAAA_BBAA);
    @(posedge clk);
    @(negedge clk);

    $display("[TB] reset mid-wait");
    applyStimulus(1, 1'b1, 32'h8000_0030, 64'h0123_4567_89AB_CDEF, 8'hFF, lat, rdata, err);
    checkOutput("l4_st_latency", 64'(lat), 64'd4);
    cur = 1'b1;
    req_wen = 1'b1; req_addr = 32'h8000_0030;
    req_wdata = 64'hFFFF_FFFF_FFFF_FFFF; req_wmask = 8'hFF;
    b_req_valid = 1'b1;
    @(posedge clk);
    #1;
    b_req_valid = 1'b0;
    @(posedge clk);
    #1;
    b_rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("mid_rst_busy", 64'(b_busy), 64'd0);
    b_rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (b_resp_valid) seen++;
      @(posedge clk);
      #1;
    end
    checkOutput("mid_rst_no_resp", 64'(seen), 64'd0);
    @(negedge clk);
    applyStimulus(1, 1'b0, 32'h8000_0030, 64'h0, 8'h00, lat, rdata, err);
    checkOutput("mid_rst_rdata", rdata, 64'h0123_4567_89AB_CDEF);

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_failures);
    $finish;
  end

endmodule
